// File: rtl/fifo_stream_drain.sv
// Drain stage after a 32x32 synchronous FIFO: turns FIFO pops into a registered valid/ready stream.
// Define FIFO_DRAIN_POPCNT_EN to build the accepted-word counter on o_pop_cnt; otherwise it is tied to zero.
module fifo_stream_drain #(
    parameter int DW        = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_fifo_empty,
    output logic          o_fifo_rd,
    input  logic [DW-1:0] i_fifo_data,
    output logic          o_m_valid,
    input  logic          i_m_ready,
    output logic [DW-1:0] o_m_data,
    output logic          o_busy,
    output logic [15:0]   o_pop_cnt
);

    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic          rd_slot_q, rd_slot_d;
    logic          wr_slot_q, wr_slot_d;
    logic [DW-1:0] buf_q [BUF_DEPTH];
    logic [DW-1:0] buf_d [BUF_DEPTH];
    logic          out_fire;
    logic [2:0]    occ_sum;
    logic          fifo_rd;

    // A pop is only issued if the word it returns next cycle is guaranteed a free slot.
    always_comb begin
        out_fire   = (occ_q != 2'd0) & i_m_ready;
        occ_sum    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, out_fire};
        fifo_rd    = !i_fifo_empty & (occ_sum < 3'd2);
        occ_d      = occ_sum[1:0];
        inflight_d = fifo_rd;
        rd_slot_d  = rd_slot_q ^ out_fire;
        wr_slot_d  = wr_slot_q ^ inflight_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            rd_slot_q  <= 1'b0;
            wr_slot_q  <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            rd_slot_q  <= rd_slot_d;
            wr_slot_q  <= wr_slot_d;
        end
    end

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
            always_comb begin
                buf_d[gi] = buf_q[gi];
                if (inflight_q && (wr_slot_q == 1'(gi)))
                    buf_d[gi] = i_fifo_data;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    buf_q[gi] <= '0;
                else
                    buf_q[gi] <= buf_d[gi];
            end
        end
    endgenerate

    assign o_fifo_rd = fifo_rd;
    assign o_m_valid = (occ_q != 2'd0);
    assign o_m_data  = buf_q[rd_slot_q];
    assign o_busy    = (occ_q != 2'd0) | inflight_q;

`ifdef FIFO_DRAIN_POPCNT_EN
    logic [15:0] pop_cnt_q, pop_cnt_d;

    always_comb begin
        pop_cnt_d = pop_cnt_q + {15'd0, out_fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pop_cnt_q <= 16'h0000;
        else
            pop_cnt_q <= pop_cnt_d;
    end

    assign o_pop_cnt = pop_cnt_q;
`else
    assign o_pop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural 32x32 FIFO upstream, scoreboard on the stream side.
module tb_fifo_stream_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic        dut_rd;
    logic [31:0] fifo_rdata;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        busy;
    logic [15:0] pop_cnt;

    logic        fifo_wr = 1'b0;
    logic [31:0] fifo_wdata = 32'd0;

    int checks = 0;
    int errors = 0;
    int fires = 0;
    int rd_violations = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_stream_drain #(.DW(32), .BUF_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd    (dut_rd),
        .i_fifo_data  (fifo_rdata),
        .o_m_valid    (m_valid),
        .i_m_ready    (m_ready),
        .o_m_data     (m_data),
        .o_busy       (busy),
        .o_pop_cnt    (pop_cnt)
    );

    // Upstream FIFO model: registered read data, combinational empty.
    logic [31:0] fmem [32];
    logic [4:0]  frp, fwp;
    logic [5:0]  fcnt;
    logic        do_w, do_r;
    assign fifo_empty = (fcnt == 6'd0);
    assign do_w = fifo_wr && (fcnt != 6'd32);
    assign do_r = dut_rd && (fcnt != 6'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frp <= 5'd0;
            fwp <= 5'd0;
            fcnt <= 6'd0;
            fifo_rdata <= 32'd0;
        end else begin
            if (do_w) begin
                fmem[fwp] <= fifo_wdata;
                fwp <= fwp + 5'd1;
            end
            if (do_r) begin
                fifo_rdata <= fmem[frp];
                frp <= frp + 5'd1;
            end
            fcnt <= fcnt + 6'(do_w) - 6'(do_r);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef FIFO_DRAIN_POPCNT_EN
        return {16'd0, 16'(n)};
`else
        return 32'd0 + 32'(n & 0);
`endif
    endfunction

    // One cycle: drive on the falling edge, sample 1ns later, score any transfer.
    task automatic step(input logic wr, input logic [31:0] wd, input logic rdy);
        @(negedge clk);
        fifo_wr = wr;
        fifo_wdata = wd;
        m_ready = rdy;
        #1;
        if (wr && fcnt != 6'd32) exp_q.push_back(wd);
        if (dut_rd && fifo_empty) rd_violations++;
        if (m_valid && m_ready) begin
            fires++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_word actual=%h required=none", m_data);
            end else begin
                chk("sb_data", m_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fifo_wr = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        fires = 0;
        rd_violations = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] wd;
        logic        rdy;
        logic        e_rd;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // Single word written at cycle 0: pop at 1, data in at 2, presented at 3.
        tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
        tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0};

        do_reset();
        chk("reset_rd", 32'(dut_rd), 32'd0);
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_data", m_data, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_popcnt", 32'(pop_cnt), 32'd0);

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wr, tbl[i].wd, tbl[i].rdy);
            chk($sformatf("single_rd_c%0d", i), 32'(dut_rd), 32'(tbl[i].e_rd));
            chk($sformatf("single_valid_c%0d", i), 32'(m_valid), 32'(tbl[i].e_valid));
            chk($sformatf("single_busy_c%0d", i), 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_valid) chk($sformatf("single_data_c%0d", i), m_data, tbl[i].e_data);
        end
        chk("single_popcnt", 32'(pop_cnt), exp_cnt(1));

        // Streaming: 32 words preloaded, then no bubbles with ready held high.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 32'(i), 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 32'd0, 1'b1);
            chk($sformatf("stream_valid_%0d", i), 32'(m_valid), 32'd1);
        end
        step(1'b0, 32'd0, 1'b1);
        chk("stream_end_valid", 32'(m_valid), 32'd0);
        chk("stream_end_busy", 32'(busy), 32'd0);
        chk("stream_count", 32'(fires), 32'd32);
        chk("stream_popcnt", 32'(pop_cnt), exp_cnt(32));

        // Backpressure: stall 5 cycles mid-stream, head must hold and pops stop.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'd0, 1'b0);
            chk($sformatf("bp_rd_%0d", k), 32'(dut_rd), 32'd0);
            chk($sformatf("bp_valid_%0d", k), 32'(m_valid), 32'd1);
            chk($sformatf("bp_data_%0d", k), m_data, (exp_q.size() != 0) ? exp_q[0] : 32'hXXXXXXXX);
        end
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("bp_left", 32'(exp_q.size()), 32'd0);
        chk("bp_count", 32'(fires), 32'd8);
        chk("bp_end_valid", 32'(m_valid), 32'd0);

        // Random writes and random ready.
        do_reset();
        begin
            int written = 0;
            for (int c = 0; c < 3000 && fires < 200; c++) begin
                logic w;
                w = (written < 200) && ($urandom_range(0, 1) == 1) && (fcnt < 6'd32);
                if (w) written++;
                step(w, $urandom, 1'($urandom_range(0, 1)));
            end
        end
        chk("rand_count", 32'(fires), 32'd200);
        chk("rand_left", 32'(exp_q.size()), 32'd0);
        chk("rand_rd_when_empty", 32'(rd_violations), 32'd0);
        step(1'b0, 32'd0, 1'b0);
        chk("rand_popcnt", 32'(pop_cnt), exp_cnt(200));

        // Reset mid-burst, then latency of a fresh word.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_rd", 32'(dut_rd), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_popcnt", 32'(pop_cnt), 32'd0);
        chk("midrst_data", m_data, 32'd0);
        exp_q.delete();
        fires = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(k == 0, 32'h00000001, 1'b1);
            chk($sformatf("postrst_valid_T%0d", k), 32'(m_valid), 32'(k == 3));
            if (k == 3) chk("postrst_data", m_data, 32'h00000001);
        end

`ifdef FIFO_DRAIN_POPCNT_EN
        // Counter wrap after 65537 transfers.
        do_reset();
        begin
            int n = 0;
            for (int i = 0; i < 20; i++) begin
                step(1'b1, 32'(n), 1'b0);
                n++;
            end
            for (int c = 0; c < 70000 && fires < 65537; c++) begin
                step(fcnt < 6'd32, 32'(n), 1'b1);
                if (fcnt < 6'd32) n++;
            end
        end
        step(1'b0, 32'd0, 1'b0);
        chk("wrap_fires", 32'(fires), 32'd65537);
        chk("wrap_popcnt", 32'(pop_cnt), 32'h0000_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
